// File: rtl/minterm_sweeper_if.sv
// rtl/minterm_sweeper_if.sv - stimulus/capture bundle between the sweeper and the function under test
interface minterm_sweeper_if;
    logic        start;
    logic        F_in;
    logic        A;
    logic        B;
    logic        C;
    logic        D;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] captured;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic        first_fail_valid;

    // Side that requests sweeps and feeds back the function output
    modport master (
        output start,
        output F_in,
        input  A,
        input  B,
        input  C,
        input  D,
        input  busy,
        input  done,
        input  pass,
        input  captured,
        input  mismatch_cnt,
        input  first_fail,
        input  first_fail_valid
    );

    // The sweeper itself
    modport slave (
        input  start,
        input  F_in,
        output A,
        output B,
        output C,
        output D,
        output busy,
        output done,
        output pass,
        output captured,
        output mismatch_cnt,
        output first_fail,
        output first_fail_valid
    );
endinterface

// File: rtl/minterm_sweeper.sv
// rtl/minterm_sweeper.sv - drives all 16 ABCD vectors, captures F and grades it against a minterm mask
module minterm_sweeper #(
    parameter logic [15:0] EXPECTED = 16'hE8F9,
    parameter int          SETTLE   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    minterm_sweeper_if.slave  bus
);

    // Settle counter reload value; the counter counts down to zero before each sample
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [3:0]  index_q;
    logic [3:0]  settle_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [15:0] captured_q;
    logic [4:0]  mismatch_cnt_q;
    logic [3:0]  first_fail_q;
    logic        first_fail_valid_q;

    logic        accept;
    logic        sample;
    logic        last;
    logic        miss;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle strobes; DONE accepts start exactly like IDLE
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        sample  = 1'b0;
        last    = 1'b0;
        miss    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (settle_q == 4'd0) begin
                    sample = 1'b1;
                    miss   = (bus.F_in != EXPECTED[index_q]);
                    if (index_q == 4'hF) begin
                        last    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Vector index and settle countdown; the index parks at 15 after a sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q  <= 4'd0;
            settle_q <= 4'd0;
        end else if (accept) begin
            index_q  <= 4'd0;
            settle_q <= SETTLE_LOAD;
        end else if (sample) begin
            if (!last) begin
                index_q  <= index_q + 4'd1;
                settle_q <= SETTLE_LOAD;
            end
        end else if (state_q == RUN) begin
            settle_q <= settle_q - 4'd1;
        end
    end

    // Truth-table capture and mismatch bookkeeping, cleared on every accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured_q         <= 16'h0000;
            mismatch_cnt_q     <= 5'd0;
            first_fail_q       <= 4'd0;
            first_fail_valid_q <= 1'b0;
        end else if (accept) begin
            captured_q         <= 16'h0000;
            mismatch_cnt_q     <= 5'd0;
            first_fail_q       <= 4'd0;
            first_fail_valid_q <= 1'b0;
        end else if (sample) begin
            captured_q[index_q] <= bus.F_in;
            if (miss) begin
                // At most 16 increments per sweep, so the 5-bit count cannot wrap
                mismatch_cnt_q <= mismatch_cnt_q + 5'd1;
                if (!first_fail_valid_q) begin
                    first_fail_q       <= index_q;
                    first_fail_valid_q <= 1'b1;
                end
            end
        end
    end

    // Sweep status: busy spans RUN, done is a single pulse, pass is graded on the final sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else if (accept) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else if (last) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (mismatch_cnt_q == 5'd0) && !miss;
        end else begin
            done_q <= 1'b0;
        end
    end

    assign bus.A                = index_q[3];
    assign bus.B                = index_q[2];
    assign bus.C                = index_q[1];
    assign bus.D                = index_q[0];
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.captured         = captured_q;
    assign bus.mismatch_cnt     = mismatch_cnt_q;
    assign bus.first_fail       = first_fail_q;
    assign bus.first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_minterm_sweeper.sv
// tb/tb_minterm_sweeper.sv - randomized and directed bench for minterm_sweeper against a timeline model
module tb_minterm_sweeper;

    localparam logic [15:0] EXP = 16'hE8F9;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    minterm_sweeper_if bus0();
    minterm_sweeper_if bus1();

    minterm_sweeper #(.EXPECTED(EXP), .SETTLE(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    minterm_sweeper #(.EXPECTED(EXP), .SETTLE(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Stimulus: start request and the truth table the emulated function block realises
    logic        start_v [2];
    logic [15:0] ftab    [2];

    assign bus0.start = start_v[0];
    assign bus1.start = start_v[1];
    assign bus0.F_in  = ftab[0][{bus0.A, bus0.B, bus0.C, bus0.D}];
    assign bus1.F_in  = ftab[1][{bus1.A, bus1.B, bus1.C, bus1.D}];

    // Observed outputs gathered into arrays so both instances share one checker
    logic        busy_o [2];
    logic        done_o [2];
    logic        pass_o [2];
    logic        ffv_o  [2];
    logic [15:0] cap_o  [2];
    logic [4:0]  mm_o   [2];
    logic [3:0]  ff_o   [2];
    logic [3:0]  idx_o  [2];

    assign busy_o[0] = bus0.busy;             assign busy_o[1] = bus1.busy;
    assign done_o[0] = bus0.done;             assign done_o[1] = bus1.done;
    assign pass_o[0] = bus0.pass;             assign pass_o[1] = bus1.pass;
    assign ffv_o[0]  = bus0.first_fail_valid; assign ffv_o[1]  = bus1.first_fail_valid;
    assign cap_o[0]  = bus0.captured;         assign cap_o[1]  = bus1.captured;
    assign mm_o[0]   = bus0.mismatch_cnt;     assign mm_o[1]   = bus1.mismatch_cnt;
    assign ff_o[0]   = bus0.first_fail;       assign ff_o[1]   = bus1.first_fail;
    assign idx_o[0]  = {bus0.A, bus0.B, bus0.C, bus0.D};
    assign idx_o[1]  = {bus1.A, bus1.B, bus1.C, bus1.D};

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Model: whether a sweep was ever accepted, edges elapsed since acceptance, table latched at acceptance
    bit          m_started [2];
    int          m_t       [2];
    logic [15:0] m_tab     [2];

    function automatic bit m_idle(input int k);
        return !(m_started[k] && (m_t[k] < 16 * settle_of(k)));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_started[k] <= 1'b0;
                m_t[k]       <= 0;
                m_tab[k]     <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (start_v[k] && m_idle(k)) begin
                    m_started[k] <= 1'b1;
                    m_t[k]       <= 0;
                    m_tab[k]     <= ftab[k];
                end else if (m_started[k] && m_t[k] <= 16 * settle_of(k)) begin
                    m_t[k] <= m_t[k] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Every cycle, derive expected outputs from elapsed time and compare both instances
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int          s;
            int          n;
            logic [15:0] mask;
            logic [15:0] diff;
            logic        e_busy;
            logic        e_done;
            logic        e_pass;
            logic [3:0]  e_idx;
            logic [3:0]  e_ff;
            s      = settle_of(k);
            mask   = 16'h0000;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_pass = 1'b0;
            e_idx  = 4'd0;
            if (m_started[k]) begin
                n = m_t[k] / s;
                if (n >= 16) mask = 16'hFFFF;
                else         mask = 16'((32'd1 << n) - 32'd1);
                e_busy = (m_t[k] < 16 * s);
                e_done = (m_t[k] == 16 * s);
                e_idx  = e_busy ? 4'(m_t[k] / s) : 4'hF;
                e_pass = !e_busy && (m_tab[k] == EXP);
            end
            diff = (m_tab[k] ^ EXP) & mask;
            e_ff = 4'd0;
            for (int j = 15; j >= 0; j--) if (diff[j]) e_ff = 4'(j);
            chk($sformatf("u%0d.busy", k),     32'(busy_o[k]), 32'(e_busy));
            chk($sformatf("u%0d.done", k),     32'(done_o[k]), 32'(e_done));
            chk($sformatf("u%0d.pass", k),     32'(pass_o[k]), 32'(e_pass));
            chk($sformatf("u%0d.abcd", k),     32'(idx_o[k]),  32'(e_idx));
            chk($sformatf("u%0d.captured", k), 32'(cap_o[k]),  32'(m_tab[k] & mask));
            chk($sformatf("u%0d.mismatch", k), 32'(mm_o[k]),   32'($countones(diff)));
            chk($sformatf("u%0d.first", k),    32'(ff_o[k]),   32'(e_ff));
            chk($sformatf("u%0d.first_v", k),  32'(ffv_o[k]),  32'(diff != 16'h0000));
        end
    end

    // Launch one sweep on instance k and return the cycles from accepting edge to done
    task automatic sweep(input int k, input logic [15:0] tab, output int lat);
        @(negedge clk);
        ftab[k]    = tab;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        lat = 0;
        while (!done_o[k] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pin_results(input string tag, input int k, input logic [15:0] cap,
                               input int mm, input int ff, input bit ffv, input bit pass);
        chk({tag, ".done"},     32'(done_o[k]), 32'd1);
        chk({tag, ".captured"}, 32'(cap_o[k]),  32'(cap));
        chk({tag, ".mismatch"}, 32'(mm_o[k]),   32'(mm));
        chk({tag, ".first"},    32'(ff_o[k]),   32'(ff));
        chk({tag, ".first_v"},  32'(ffv_o[k]),  32'(ffv));
        chk({tag, ".pass"},     32'(pass_o[k]), 32'(pass));
    endtask

    initial begin
        int lat;
        int cnt;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        ftab[0] = EXP;     ftab[1] = EXP;
        #1 rst_n = 1'b0;

        // Reset held: clock and start must not disturb anything
        repeat (2) @(negedge clk);
        start_v[0] = 1'b1; start_v[1] = 1'b1;
        repeat (2) @(negedge clk);
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        chk("rst.busy", 32'(busy_o[0]), 32'd0);
        chk("rst.captured", 32'(cap_o[1]), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle.abcd", 32'(idx_o[0]), 32'd0);

        // Golden, stuck-at-0, single fault, stuck-at-1 on the SETTLE=1 unit
        sweep(0, EXP, lat);
        chk("golden.latency", 32'(lat), 32'd16);
        pin_results("golden", 0, 16'hE8F9, 0, 0, 1'b0, 1'b1);
        sweep(0, 16'h0000, lat);
        pin_results("stuck0", 0, 16'h0000, 10, 0, 1'b1, 1'b0);
        sweep(0, 16'hEAF9, lat);
        pin_results("flip9", 0, 16'hEAF9, 1, 9, 1'b1, 1'b0);
        sweep(0, 16'hFFFF, lat);
        pin_results("stuck1", 0, 16'hFFFF, 6, 1, 1'b1, 1'b0);

        // SETTLE=3 with start hammered while busy
        @(negedge clk);
        ftab[1]    = EXP;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        cnt = 0;
        while (!done_o[1] && cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (!done_o[1]) start_v[1] = (cnt % 5 == 0);
        end
        start_v[1] = 1'b0;
        chk("settle3.latency", 32'(cnt), 32'd48);
        pin_results("settle3", 1, 16'hE8F9, 0, 0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("settle3.no_rerun", 32'(busy_o[1]), 32'd0);

        // Start in the DONE cycle: back-to-back sweep, results cleared at the accepting edge
        sweep(0, EXP, lat);
        ftab[0]    = 16'h0000;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("b2b.busy", 32'(busy_o[0]), 32'd1);
        chk("b2b.cleared", 32'(cap_o[0]), 32'd0);
        chk("b2b.pass_cleared", 32'(pass_o[0]), 32'd0);
        cnt = 0;
        while (!done_o[0] && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        pin_results("b2b", 0, 16'h0000, 10, 0, 1'b1, 1'b0);

        // Abort at vector 7, then a clean golden sweep
        @(negedge clk);
        ftab[0]    = EXP;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cnt = 0;
        while (idx_o[0] != 4'd7 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("abort.reached7", 32'(idx_o[0]), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy_o[0]), 32'd0);
        chk("abort.abcd", 32'(idx_o[0]), 32'd0);
        chk("abort.captured", 32'(cap_o[0]), 32'd0);
        chk("abort.mismatch", 32'(mm_o[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        sweep(0, EXP, lat);
        pin_results("post_abort", 0, 16'hE8F9, 0, 0, 1'b0, 1'b1);

        // Randomized phase: random tables, random starts, rare resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            for (int k = 0; k < 2; k++) begin
                start_v[k] = 1'b0;
                if ($urandom_range(0, 7) == 0) begin
                    if (m_idle(k)) begin
                        case ($urandom_range(0, 3))
                            0:       ftab[k] = EXP;
                            1:       ftab[k] = 16'($urandom);
                            default: ftab[k] = EXP ^ 16'($urandom & $urandom & $urandom);
                        endcase
                    end
                    start_v[k] = 1'b1;
                end
            end
        end
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        rst_n = 1'b1;
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
